// File: rtl/cordic_dual_mode_if.sv
// Request/result bundle for the dual-mode CORDIC engine.
// Requester drives start and operands; the engine returns busy, a done pulse and results.
interface cordic_dual_mode_if #(
    parameter int WIDTH   = 16,
    parameter int ANGLE_W = 16
);
    logic                      crd_start;
    logic                      mode;
    logic signed [WIDTH-1:0]   x_in;
    logic signed [WIDTH-1:0]   y_in;
    logic signed [ANGLE_W-1:0] z_in;
    logic                      busy;
    logic                      crd_done;
    logic signed [WIDTH:0]     x_out;
    logic signed [WIDTH:0]     y_out;
    logic signed [ANGLE_W-1:0] z_out;

    modport master (
        output crd_start, mode, x_in, y_in, z_in,
        input  busy, crd_done, x_out, y_out, z_out
    );

    modport slave (
        input  crd_start, mode, x_in, y_in, z_in,
        output busy, crd_done, x_out, y_out, z_out
    );
endinterface

// File: rtl/cordic_dual_mode.sv
// Iterative CORDIC: full-circle vectoring (atan2 + magnitude) or rotation, one request in flight.
// Latency ITERATIONS+2 clocks for every input; no backpressure, crd_start is ignored while busy.
module cordic_dual_mode #(
    parameter int WIDTH      = 16,
    parameter int ANGLE_W    = 16,
    parameter int ITERATIONS = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic_dual_mode_if.slave bus
);
    localparam int XW  = WIDTH + 3;
    localparam int PW  = XW + 16;
    localparam int ASH = 32 - ANGLE_W;
    localparam logic [32:0] RND = (33'd1 << ASH) >> 1;
    localparam logic signed [15:0] K_GAIN = 16'sd19898;
    localparam logic signed [ANGLE_W-1:0] QUARTER  = {2'b01, {(ANGLE_W-2){1'b0}}};
    localparam logic signed [ANGLE_W-1:0] NQUARTER = {2'b11, {(ANGLE_W-2){1'b0}}};
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-WIDTH){1'b1}}, {WIDTH{1'b0}}};
    localparam logic [4:0] LAST = 5'(ITERATIONS - 1);

    typedef enum logic [1:0] {IDLE, ITER, SCALE, OUT} state_t;

    // 32-bit binary-angle atan(2^-i), rounded half-up down to ANGLE_W bits.
    function automatic logic signed [ANGLE_W-1:0] atan_entry(input int i);
        logic [31:0] a;
        logic [32:0] s;
        case (i)
            0:  a = 32'd536870912;
            1:  a = 32'd316933406;
            2:  a = 32'd167458907;
            3:  a = 32'd85004756;
            4:  a = 32'd42667331;
            5:  a = 32'd21354465;
            6:  a = 32'd10679838;
            7:  a = 32'd5340245;
            8:  a = 32'd2670163;
            9:  a = 32'd1335087;
            10: a = 32'd667544;
            11: a = 32'd333772;
            12: a = 32'd166886;
            13: a = 32'd83443;
            14: a = 32'd41722;
            15: a = 32'd20861;
            16: a = 32'd10430;
            17: a = 32'd5215;
            18: a = 32'd2608;
            19: a = 32'd1304;
            20: a = 32'd652;
            21: a = 32'd326;
            22: a = 32'd163;
            23: a = 32'd81;
            default: a = 32'd0;
        endcase
        s = ({1'b0, a} + RND) >> ASH;
        return s[ANGLE_W-1:0];
    endfunction

    function automatic logic signed [WIDTH:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[WIDTH:0];
        else if (v < SAT_MIN) return SAT_MIN[WIDTH:0];
        else                  return v[WIDTH:0];
    endfunction

    logic signed [ANGLE_W-1:0] atan_tab [32];
    for (genvar g = 0; g < 32; g++) begin : g_atan
        assign atan_tab[g] = atan_entry(g);
    end

    state_t                    state, state_nxt;
    logic signed [XW-1:0]      xr, yr, xe, ye, x0, y0, xs, ys, x_nx, y_nx;
    logic signed [ANGLE_W-1:0] zr, z0, z_nx;
    logic signed [PW-1:0]      p, q, p_sh, q_sh;
    logic [4:0]                iter;
    logic                      vec_mode, zero_flg, d_pos;

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.crd_start) state_nxt = ITER;
            ITER:    if (iter == LAST)  state_nxt = SCALE;
            SCALE:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Quadrant pre-rotation keeps the iterative stage inside its ~99 degree convergence range.
    always_comb begin
        xe = {{3{bus.x_in[WIDTH-1]}}, bus.x_in};
        ye = {{3{bus.y_in[WIDTH-1]}}, bus.y_in};
        x0 = xe;
        y0 = ye;
        z0 = '0;
        if (!bus.mode) begin
            if (bus.x_in[WIDTH-1]) begin
                if (!bus.y_in[WIDTH-1]) begin
                    x0 = ye;  y0 = -xe; z0 = QUARTER;
                end else begin
                    x0 = -ye; y0 = xe;  z0 = NQUARTER;
                end
            end
        end else begin
            z0 = bus.z_in;
            if (bus.z_in > QUARTER) begin
                x0 = -ye; y0 = xe;  z0 = bus.z_in - QUARTER;
            end else if (bus.z_in < NQUARTER) begin
                x0 = ye;  y0 = -xe; z0 = bus.z_in + QUARTER;
            end
        end
    end

    always_comb begin
        xs    = xr >>> iter;
        ys    = yr >>> iter;
        d_pos = vec_mode ? yr[XW-1] : ~zr[ANGLE_W-1];
        x_nx  = d_pos ? xr - ys : xr + ys;
        y_nx  = d_pos ? yr + xs : yr - xs;
        z_nx  = d_pos ? zr - atan_tab[iter] : zr + atan_tab[iter];
        p_sh  = p >>> 15;
        q_sh  = q >>> 15;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr <= '0; yr <= '0; zr <= '0; iter <= '0;
            vec_mode <= 1'b0; zero_flg <= 1'b0;
            p <= '0; q <= '0;
            bus.crd_done <= 1'b0;
            bus.x_out <= '0; bus.y_out <= '0; bus.z_out <= '0;
        end else begin
            bus.crd_done <= 1'b0;
            case (state)
                IDLE: if (bus.crd_start) begin
                    xr       <= x0;
                    yr       <= y0;
                    zr       <= z0;
                    iter     <= '0;
                    vec_mode <= ~bus.mode;
                    zero_flg <= ~bus.mode && (bus.x_in == '0) && (bus.y_in == '0);
                end
                ITER: begin
                    xr   <= x_nx;
                    yr   <= y_nx;
                    zr   <= z_nx;
                    iter <= iter + 5'd1;
                end
                SCALE: begin
                    p <= xr * K_GAIN;
                    q <= yr * K_GAIN;
                end
                OUT: begin
                    bus.x_out    <= zero_flg ? '0 : sat(p_sh);
                    bus.y_out    <= vec_mode ? '0 : sat(q_sh);
                    bus.z_out    <= zero_flg ? '0 : zr;
                    bus.crd_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_dual_mode.sv
// Scoreboarded bench for cordic_dual_mode: a real-math model queues expected results per request.
module tb_cordic_dual_mode;
    localparam real PI  = 3.14159265358979;
    localparam int  LAT = 16;

    typedef struct {
        string tag;
        int    ex, ey, ez;
        int    tx, ty, tz;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   n_pushed = 0;
    int   busy_cnt = 0;
    exp_t sb [$];

    cordic_dual_mode_if #(.WIDTH(16), .ANGLE_W(16)) bus ();

    cordic_dual_mode #(.WIDTH(16), .ANGLE_W(16), .ITERATIONS(14)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol, input bit ang);
        longint d;
        logic signed [15:0] w;
        n_checks++;
        d = obs - exp;
        if (ang) begin
            w = d[15:0];
            d = w;
        end
        if (d > tol || d < -tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic expect_res(input string tag, input bit m, input int x, input int y,
                              input int z, input int done_cyc);
        exp_t e;
        real  th;
        e.tag = tag;
        e.cyc = done_cyc;
        if (!m) begin
            e.ex = int'($sqrt(real'(x) * x + real'(y) * y));
            e.ey = 0;
            e.ez = int'($atan2(real'(y), real'(x)) * 32768.0 / PI);
            e.tx = 20; e.ty = 0; e.tz = 8;
            if (x == 0 && y == 0) begin
                e.ex = 0; e.ez = 0; e.tx = 0; e.tz = 0;
            end
        end else begin
            th   = real'(z) * PI / 32768.0;
            e.ex = int'(x * $cos(th) - y * $sin(th));
            e.ey = int'(x * $sin(th) + y * $cos(th));
            e.ez = 0;
            e.tx = 20; e.ty = 20; e.tz = 8;
        end
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
        if (bus.busy) check("idle_timeout", 1, 0, 0, 0);
    endtask

    task automatic drive(input bit m, input int x, input int y, input int z);
        bus.mode      = m;
        bus.x_in      = x[15:0];
        bus.y_in      = y[15:0];
        bus.z_in      = z[15:0];
        bus.crd_start = 1'b1;
        @(posedge clk);
        #1 bus.crd_start = 1'b0;
    endtask

    task automatic issue(input string tag, input bit m, input int x, input int y, input int z);
        wait_idle();
        expect_res(tag, m, x, y, z, cyc + 1 + LAT);
        drive(m, x, y, z);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0, 0, 0);
            sb.delete();
        end
    endtask

    // Result monitor: pops the scoreboard on every done pulse.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            busy_cnt = 0;
        end else if (bus.crd_done) begin
            n_done++;
            check("busy_cycles", busy_cnt, LAT, 0, 0);
            check("busy_low_at_done", bus.busy, 0, 0, 0);
            busy_cnt = 0;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0, 0, 0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_lat"}, cyc, e.cyc, 0, 0);
                check({e.tag, "_x"}, bus.x_out, e.ex, e.tx, 0);
                check({e.tag, "_y"}, bus.y_out, e.ey, e.ty, 0);
                check({e.tag, "_z"}, bus.z_out, e.ez, e.tz, 1);
            end
        end else if (bus.busy) begin
            busy_cnt++;
        end
    end

    initial begin
        int vx [6] = '{10000, -10000, 0, -10000, 0, -32768};
        int vy [6] = '{10000, 0, -20000, -10000, 0, -32768};
        int rz [3] = '{16384, -32768, 5461};
        int k, a, r;
        real th;

        bus.crd_start = 1'b0;
        bus.mode      = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.z_in      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0, 0, 0);
        check("rst_done", bus.crd_done, 0, 0, 0);
        check("rst_x", bus.x_out, 0, 0, 0);
        check("rst_y", bus.y_out, 0, 0, 0);
        check("rst_z", bus.z_out, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            issue($sformatf("vec%0d", i), 1'b0, vx[i], vy[i], 0);
            drain();
        end
        for (int i = 0; i < 3; i++) begin
            issue($sformatf("rot%0d", i), 1'b1, 20000, 0, rz[i]);
            drain();
        end

        for (int i = 0; i < 6; i++) begin
            a  = int'($urandom_range(65535)) - 32768;
            r  = int'($urandom_range(30000, 20000));
            th = real'(a) * PI / 32768.0;
            issue($sformatf("rvec%0d", i), 1'b0, int'(r * $cos(th)), int'(r * $sin(th)), 0);
            drain();
            a  = int'($urandom_range(65535)) - 32768;
            r  = int'($urandom_range(20000, 10000));
            th = real'($urandom_range(65535)) * PI / 32768.0;
            issue($sformatf("rrot%0d", i), 1'b1, int'(r * $cos(th)), int'(r * $sin(th)), a);
            drain();
        end

        // Starts while busy and operand changes after capture must not disturb the result.
        issue("ignore", 1'b0, 12000, 5000, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.x_in = 16'sd1234; bus.y_in = -16'sd999; bus.mode = 1'b1; bus.crd_start = 1'b1;
        @(negedge clk);
        bus.crd_start = 1'b0;
        repeat (5) @(negedge clk);
        bus.crd_start = 1'b1;
        @(negedge clk);
        bus.crd_start = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        check("ignore_single_done", n_done, n_pushed, 0, 0);

        // Back-to-back: next start is driven in the done cycle.
        issue("b2b_a", 1'b0, -15000, 9000, 0);
        for (int i = 0; i < 100 && !bus.crd_done; i++) @(negedge clk);
        if (!bus.crd_done) check("b2b_done_timeout", 0, 1, 0, 0);
        expect_res("b2b_b", 1'b1, 15000, 3000, -9000, cyc + 1 + LAT);
        drive(1'b1, 15000, 3000, -9000);
        drain();

        // Reset during iteration 6 aborts the request and clears outputs.
        wait_idle();
        k = cyc + 1;
        drive(1'b0, 7000, -21000, 0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cycle", cyc, k + 6, 0, 0);
        check("mid_rst_busy", bus.busy, 0, 0, 0);
        check("mid_rst_done", bus.crd_done, 0, 0, 0);
        check("mid_rst_x", bus.x_out, 0, 0, 0);
        check("mid_rst_y", bus.y_out, 0, 0, 0);
        check("mid_rst_z", bus.z_out, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue("after_rst", 1'b0, -3000, 25000, 0);
        drain();
        repeat (20) @(negedge clk);
        check("done_count", n_done, n_pushed, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, want finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
